l2_access_arbiter: RTL and testbench
====================================

Name: l2_access_arbiter

Overview:
- Sits between the I-Cache and D-Cache controllers and the single L2 cache port.
- Accepts miss requests from both L1 caches and grants L2 to exactly one at a time, driving the grant lines `ic_en` / `dc_en`.
- Forwards the granted requester's block address and read/write control to L2.
- Holds the grant through the L2 data return and the L1 fill, releasing it on the requester's fill-complete pulse.

Parameters:
- ADDR_W, 28, block-address width (word address bits [29:2]).
- FILL_TIMEOUT, 16, max cycles allowed from `l2_rdy` to the fill-complete pulse before forced release.
- CNT_W, 5, fill watchdog counter width; must satisfy 2^CNT_W > FILL_TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- irq  in  1  I-Cache miss request, level, held until its `ic_complete`
- ic_addr  in  ADDR_W  I-Cache block address
- ic_complete  in  1  I-Cache fill done, 1-cycle pulse
- drq  in  1  D-Cache miss request, level, held until its `dc_complete`
- dc_addr  in  ADDR_W  D-Cache block address
- dc_rw  in  1  D-Cache L2 op (0 read, 1 write-back)
- dc_complete  in  1  D-Cache fill done, 1-cycle pulse
- l2_rdy  in  1  L2 data valid / op done, 1-cycle pulse
- ic_en  out  1  I-Cache owns L2
- dc_en  out  1  D-Cache owns L2
- l2_req  out  1  request strobe to L2, level until `l2_rdy`
- l2_addr  out  ADDR_W  address to L2
- l2_rw  out  1  op to L2
- fill_err  out  1  sticky: fill watchdog expired

Behaviour:

Reset and output timing
- On a clock edge with `rst`=0, all of the following are cleared:
  - state=ARB_IDLE;
  - `ic_en`, `dc_en`, `l2_req`, `l2_rw`, `fill_err` = 0;
  - `l2_addr` = 0;
  - `last_grant` = DC, so the I-Cache wins the first tie;
  - watchdog counter = 0.
- All outputs are registered; none are combinational from inputs.
- Reset mid-transaction drops the grant in the next cycle. No further outputs are produced for the aborted access.

States
- ARB_IDLE
  - No request: stay.
  - Only `irq`: go to ARB_IC.
  - Only `drq`: go to ARB_DC.
  - Both: grant the requester not equal to `last_grant` (round-robin).
  - On entry to a grant state, the selected requester's address is registered into `l2_addr`, and `l2_rw` is set (0 for IC, `dc_rw` for DC).
  - Entering the grant state sets the matching `en` and `l2_req`=1.
- ARB_IC / ARB_DC (request phase)
  - `l2_req`=1, `l2_addr` and `l2_rw` stable.
  - On `l2_rdy`: `l2_req` goes 0 next cycle, watchdog is cleared, go to ARB_IC_FILL / ARB_DC_FILL.
  - Requester input changes during this phase are ignored (address latched).
- ARB_IC_FILL / ARB_DC_FILL
  - `en` stays 1 and the watchdog increments each cycle.
  - On the matching complete pulse: `en` goes 0, `last_grant` is updated, go to ARB_IDLE.
  - If the watchdog reaches FILL_TIMEOUT first: same release, and `fill_err` is set.
- Complete arriving in the same cycle as `l2_rdy` (same-cycle fill): release directly from the request state to ARB_IDLE.
- Complete pulses from the non-granted cache are ignored.

Latency and bubbles
- `l2_req` rises 1 cycle after the request is sampled in ARB_IDLE.
- After a release there is a 1-cycle idle bubble before the next grant.

Invariants
- `ic_en` & `dc_en` is never 1 in the same cycle.
- `l2_req`=1 implies exactly one `en`=1.

`fill_err`
- Cleared only by reset.

Optional Feature:
Macro: L2_ARB_ICACHE_PRIO_EN.
- Defined: fixed priority. On a tie the I-Cache always wins; `last_grant` is not used.
- Undefined: round-robin as described under Behaviour.

Test Plan:
1. Single IC miss: `irq`=1, `ic_addr`=28'h0000123, L2 pulses `l2_rdy` 3 cycles later, `ic_complete` 1 cycle after that.
   -> `ic_en`=1 and `l2_req`=1 one cycle after `irq`; `l2_addr`=28'h0000123, `l2_rw`=0; `l2_req` drops after `l2_rdy`; `ic_en` drops the cycle after `ic_complete`; `dc_en` stays 0 throughout.
2. Simultaneous `irq`/`drq` from reset, three back-to-back rounds.
   -> Grant order IC, DC, IC (DC, IC, DC if `last_grant`=IC beforehand).
   -> With L2_ARB_ICACHE_PRIO_EN: IC on every tie, DC only when `irq`=0.
3. DC write-back: `drq`=1, `dc_rw`=1, `dc_addr`=28'hABCDEF0.
   -> `l2_rw`=1, `l2_addr`=28'hABCDEF0.
   -> Changing `dc_addr` to 28'h1 mid-request leaves `l2_addr` unchanged.
4. Fill timeout: grant IC, pulse `l2_rdy`, never pulse `ic_complete`.
   -> `ic_en` drops after 16 fill cycles; `fill_err`=1 and stays 1; a subsequent `drq` is granted normally.
5. Stray completion: `dc_complete` pulsed during ARB_IC_FILL.
   -> No release.
   -> Same-cycle `l2_rdy`+`ic_complete` releases immediately to ARB_IDLE.
6. Reset mid-operation: `rst`=0 during ARB_IC.
   -> Next cycle all outputs are 0 and state=ARB_IDLE; after reset is released, a pending `irq` is re-granted.

Source files
------------

// File: rtl/l2_access_arbiter.sv
// Arbitrates the single L2 port between I-Cache and D-Cache misses; grant held through fill.
// Define L2_ARB_ICACHE_PRIO_EN for fixed I-Cache priority on ties instead of round-robin.
module l2_access_arbiter #(
  parameter int ADDR_W       = 28,
  parameter int FILL_TIMEOUT = 16,
  parameter int CNT_W        = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic              ic_complete,
  input  logic              drq,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic              dc_rw,
  input  logic              dc_complete,
  input  logic              l2_rdy,
  output logic              ic_en,
  output logic              dc_en,
  output logic              l2_req,
  output logic [ADDR_W-1:0] l2_addr,
  output logic              l2_rw,
  output logic              fill_err
);

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_IC,
    ARB_DC,
    ARB_IC_FILL,
    ARB_DC_FILL
  } arb_state_t;

  localparam logic GRANT_IC = 1'b0;
  localparam logic GRANT_DC = 1'b1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(FILL_TIMEOUT - 1);

  arb_state_t        state, state_nxt;
  logic              ic_en_nxt, dc_en_nxt, l2_req_nxt, l2_rw_nxt, fill_err_nxt;
  logic [ADDR_W-1:0] l2_addr_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  wdog, wdog_nxt;
  logic              pick_ic;

  // Tie resolution between simultaneous misses
  always_comb begin
`ifdef L2_ARB_ICACHE_PRIO_EN
    pick_ic = irq;
`else
    pick_ic = irq && (!drq || (last_grant == GRANT_DC));
`endif
  end

  always_comb begin
    state_nxt      = state;
    ic_en_nxt      = ic_en;
    dc_en_nxt      = dc_en;
    l2_req_nxt     = l2_req;
    l2_addr_nxt    = l2_addr;
    l2_rw_nxt      = l2_rw;
    fill_err_nxt   = fill_err;
    last_grant_nxt = last_grant;
    wdog_nxt       = wdog;
    case (state)
      ARB_IDLE: begin
        if (pick_ic) begin
          state_nxt   = ARB_IC;
          ic_en_nxt   = 1'b1;
          l2_req_nxt  = 1'b1;
          l2_addr_nxt = ic_addr;
          l2_rw_nxt   = 1'b0;
        end else if (drq) begin
          state_nxt   = ARB_DC;
          dc_en_nxt   = 1'b1;
          l2_req_nxt  = 1'b1;
          l2_addr_nxt = dc_addr;
          l2_rw_nxt   = dc_rw;
        end
      end
      ARB_IC: begin
        if (l2_rdy) begin
          l2_req_nxt = 1'b0;
          wdog_nxt   = '0;
          if (ic_complete) begin
            state_nxt      = ARB_IDLE;
            ic_en_nxt      = 1'b0;
            last_grant_nxt = GRANT_IC;
          end else begin
            state_nxt = ARB_IC_FILL;
          end
        end
      end
      ARB_DC: begin
        if (l2_rdy) begin
          l2_req_nxt = 1'b0;
          wdog_nxt   = '0;
          if (dc_complete) begin
            state_nxt      = ARB_IDLE;
            dc_en_nxt      = 1'b0;
            last_grant_nxt = GRANT_DC;
          end else begin
            state_nxt = ARB_DC_FILL;
          end
        end
      end
      ARB_IC_FILL: begin
        wdog_nxt = wdog + 1'b1;
        if (ic_complete || (wdog == WDOG_LAST)) begin
          state_nxt      = ARB_IDLE;
          ic_en_nxt      = 1'b0;
          last_grant_nxt = GRANT_IC;
          if (!ic_complete) fill_err_nxt = 1'b1;
        end
      end
      ARB_DC_FILL: begin
        wdog_nxt = wdog + 1'b1;
        if (dc_complete || (wdog == WDOG_LAST)) begin
          state_nxt      = ARB_IDLE;
          dc_en_nxt      = 1'b0;
          last_grant_nxt = GRANT_DC;
          if (!dc_complete) fill_err_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt  = ARB_IDLE;
        ic_en_nxt  = 1'b0;
        dc_en_nxt  = 1'b0;
        l2_req_nxt = 1'b0;
      end
    endcase
  end

  // Registered outputs and arbitration state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      ic_en      <= 1'b0;
      dc_en      <= 1'b0;
      l2_req     <= 1'b0;
      l2_addr    <= '0;
      l2_rw      <= 1'b0;
      fill_err   <= 1'b0;
      last_grant <= GRANT_DC;
      wdog       <= '0;
    end else begin
      state      <= state_nxt;
      ic_en      <= ic_en_nxt;
      dc_en      <= dc_en_nxt;
      l2_req     <= l2_req_nxt;
      l2_addr    <= l2_addr_nxt;
      l2_rw      <= l2_rw_nxt;
      fill_err   <= fill_err_nxt;
      last_grant <= last_grant_nxt;
      wdog       <= wdog_nxt;
    end
  end

endmodule

// File: tb/tb_l2_access_arbiter.sv
// Directed bench for l2_access_arbiter: grant, round-robin, write-back, watchdog, stray complete, reset.
module tb_l2_access_arbiter;

  localparam int ADDR_W = 28;

  logic              clk = 1'b0;
  logic              rst;
  logic              irq, ic_complete, drq, dc_rw, dc_complete, l2_rdy;
  logic [ADDR_W-1:0] ic_addr, dc_addr;
  logic              ic_en, dc_en, l2_req, l2_rw, fill_err;
  logic [ADDR_W-1:0] l2_addr;

  int n_checks = 0;
  int n_pass   = 0;

  l2_access_arbiter #(.ADDR_W(ADDR_W), .FILL_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .irq(irq), .ic_addr(ic_addr), .ic_complete(ic_complete),
    .drq(drq), .dc_addr(dc_addr), .dc_rw(dc_rw), .dc_complete(dc_complete),
    .l2_rdy(l2_rdy),
    .ic_en(ic_en), .dc_en(dc_en), .l2_req(l2_req),
    .l2_addr(l2_addr), .l2_rw(l2_rw), .fill_err(fill_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One tie round: both requesting in idle, winner completes, request re-raised
  task automatic tie_round(input string tag, input logic exp_ic);
    tick();
    check_eq({tag, "_ic_en"}, 32'(ic_en), 32'(exp_ic));
    check_eq({tag, "_dc_en"}, 32'(dc_en), 32'(!exp_ic));
    check_eq({tag, "_addr"}, 32'(l2_addr), exp_ic ? 32'h0000111 : 32'h0000222);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    check_eq({tag, "_req_drop"}, 32'(l2_req), 32'd0);
    if (exp_ic) begin ic_complete = 1'b1; irq = 1'b0; end
    else        begin dc_complete = 1'b1; drq = 1'b0; end
    tick();
    ic_complete = 1'b0;
    dc_complete = 1'b0;
    check_eq({tag, "_release"}, 32'({ic_en, dc_en}), 32'd0);
    irq = 1'b1;
    drq = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    irq = 1'b0; ic_complete = 1'b0; drq = 1'b0; dc_rw = 1'b0;
    dc_complete = 1'b0; l2_rdy = 1'b0;
    ic_addr = '0; dc_addr = '0;
    tick();
    tick();
    check_eq("rst_ic_en", 32'(ic_en), 32'd0);
    check_eq("rst_dc_en", 32'(dc_en), 32'd0);
    check_eq("rst_l2_req", 32'(l2_req), 32'd0);
    check_eq("rst_l2_addr", 32'(l2_addr), 32'd0);
    check_eq("rst_l2_rw", 32'(l2_rw), 32'd0);
    check_eq("rst_fill_err", 32'(fill_err), 32'd0);
    rst = 1'b1;
    tick();

    // Single IC miss
    irq = 1'b1;
    ic_addr = 28'h0000123;
    tick();
    check_eq("t1_ic_en", 32'(ic_en), 32'd1);
    check_eq("t1_l2_req", 32'(l2_req), 32'd1);
    check_eq("t1_addr", 32'(l2_addr), 32'h0000123);
    check_eq("t1_rw", 32'(l2_rw), 32'd0);
    check_eq("t1_dc_en", 32'(dc_en), 32'd0);
    tick();
    tick();
    check_eq("t1_req_hold", 32'(l2_req), 32'd1);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    check_eq("t1_req_drop", 32'(l2_req), 32'd0);
    check_eq("t1_ic_en_fill", 32'(ic_en), 32'd1);
    ic_complete = 1'b1;
    irq = 1'b0;
    tick();
    ic_complete = 1'b0;
    check_eq("t1_ic_release", 32'(ic_en), 32'd0);
    check_eq("t1_dc_en_end", 32'(dc_en), 32'd0);
    tick();
    check_eq("t1_idle", 32'({ic_en, dc_en, l2_req}), 32'd0);

    // Ties from reset: round-robin IC, DC, IC
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ic_addr = 28'h0000111;
    dc_addr = 28'h0000222;
    dc_rw = 1'b0;
    irq = 1'b1;
    drq = 1'b1;
    tie_round("t2_r1", 1'b1);
`ifdef L2_ARB_ICACHE_PRIO_EN
    tie_round("t2_r2", 1'b1);
`else
    tie_round("t2_r2", 1'b0);
`endif
    tie_round("t2_r3", 1'b1);
    irq = 1'b0;
    drq = 1'b0;
    tick();

    // DC write-back with address change mid-request
    drq = 1'b1;
    dc_rw = 1'b1;
    dc_addr = 28'hABCDEF0;
    tick();
    check_eq("t3_dc_en", 32'(dc_en), 32'd1);
    check_eq("t3_rw", 32'(l2_rw), 32'd1);
    check_eq("t3_addr", 32'(l2_addr), 32'hABCDEF0);
    dc_addr = 28'h0000001;
    dc_rw = 1'b0;
    tick();
    check_eq("t3_addr_latched", 32'(l2_addr), 32'hABCDEF0);
    check_eq("t3_rw_latched", 32'(l2_rw), 32'd1);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    dc_complete = 1'b1;
    drq = 1'b0;
    tick();
    dc_complete = 1'b0;
    check_eq("t3_release", 32'(dc_en), 32'd0);

    // Fill watchdog expiry
    irq = 1'b1;
    ic_addr = 28'h0000055;
    tick();
    check_eq("t4_ic_en", 32'(ic_en), 32'd1);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    irq = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check_eq("t4_ic_en_15", 32'(ic_en), 32'd1);
    check_eq("t4_err_15", 32'(fill_err), 32'd0);
    tick();
    check_eq("t4_ic_en_16", 32'(ic_en), 32'd0);
    check_eq("t4_err_16", 32'(fill_err), 32'd1);
    drq = 1'b1;
    dc_addr = 28'h0000077;
    dc_rw = 1'b0;
    tick();
    check_eq("t4_dc_grant", 32'(dc_en), 32'd1);
    check_eq("t4_dc_addr", 32'(l2_addr), 32'h0000077);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    dc_complete = 1'b1;
    drq = 1'b0;
    tick();
    dc_complete = 1'b0;
    check_eq("t4_dc_release", 32'(dc_en), 32'd0);
    check_eq("t4_err_sticky", 32'(fill_err), 32'd1);

    // Stray DC completion during IC fill, then same-cycle fill
    irq = 1'b1;
    ic_addr = 28'h0000099;
    tick();
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    dc_complete = 1'b1;
    tick();
    dc_complete = 1'b0;
    check_eq("t5_no_release", 32'(ic_en), 32'd1);
    check_eq("t5_dc_en", 32'(dc_en), 32'd0);
    ic_complete = 1'b1;
    irq = 1'b0;
    tick();
    ic_complete = 1'b0;
    check_eq("t5_release", 32'(ic_en), 32'd0);
    irq = 1'b1;
    tick();
    check_eq("t5_sc_grant", 32'(ic_en), 32'd1);
    l2_rdy = 1'b1;
    ic_complete = 1'b1;
    irq = 1'b0;
    tick();
    l2_rdy = 1'b0;
    ic_complete = 1'b0;
    check_eq("t5_sc_release", 32'({ic_en, l2_req}), 32'd0);
    drq = 1'b1;
    tick();
    check_eq("t5_sc_next_grant", 32'(dc_en), 32'd1);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    dc_complete = 1'b1;
    drq = 1'b0;
    tick();
    dc_complete = 1'b0;

    // Reset during the request phase
    irq = 1'b1;
    ic_addr = 28'h0000042;
    tick();
    check_eq("t6_ic_en", 32'(ic_en), 32'd1);
    rst = 1'b0;
    tick();
    check_eq("t6_rst_outs", 32'({ic_en, dc_en, l2_req, l2_rw, fill_err}), 32'd0);
    check_eq("t6_rst_addr", 32'(l2_addr), 32'd0);
    rst = 1'b1;
    tick();
    check_eq("t6_regrant", 32'(ic_en), 32'd1);
    check_eq("t6_regrant_addr", 32'(l2_addr), 32'h0000042);
    l2_rdy = 1'b1;
    tick();
    l2_rdy = 1'b0;
    ic_complete = 1'b1;
    irq = 1'b0;
    tick();
    ic_complete = 1'b0;
    check_eq("t6_release", 32'(ic_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  always @(negedge clk) begin
    if (rst && ic_en && dc_en) begin
      $display("FAIL both_en: got ic_en=%b dc_en=%b expected not both", ic_en, dc_en);
      n_checks++;
    end
  end

endmodule
